exec_stage: RTL and testbench
=============================

# exec_stage

Single-issue execute/write-back sequencer that sits directly downstream of the 8×32 register bank. It accepts one instruction at a time (op, dst, src1, src2) and drives the bank's read addresses. It captures the bank's registered read data, computes an ALU or iterative multiply result, and drives the bank's write port for exactly one cycle. One instruction is in flight at a time, so there are no read-after-write hazards and no forwarding.

## Interface
Parameters:
- WIDTH, 32, datapath width; must match the bank data width
- AW, 3, register address width; must match the bank address width

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  reset, synchronous, active-high
- issue_valid  in  1  instruction presented
- issue_ready  out  1  block can accept; high only in IDLE
- op  in  3  opcode, sampled on accept
- dst  in  AW  destination register, sampled on accept
- src1  in  AW  first source register, sampled on accept
- src2  in  AW  second source register, sampled on accept
- rd_addr1  out  AW  to bank readReg1, registered
- rd_addr2  out  AW  to bank readReg2, registered
- rd_data1  in  WIDTH  from bank readData1; valid one cycle after address
- rd_data2  in  WIDTH  from bank readData2
- reg_write  out  1  to bank regWrite; one-cycle pulse
- wr_addr  out  AW  to bank writeReg
- wr_data  out  WIDTH  to bank writeData
- done  out  1  pulse coincident with reg_write, or with err
- err  out  1  one-cycle pulse on an illegal op
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: signed compare; result 1 or 0, zero-extended
  - 110 MUL: low WIDTH bits of the unsigned product
  - 111 MOV: result = src1 data
- Arithmetic is modulo 2^WIDTH. Carries and overflow are discarded.
- Accept occurs when issue_valid && issue_ready at a rising edge. On accept:
  - op, dst latch into internal registers
  - rd_addr1 <= src1, rd_addr2 <= src2
  - state <= READ
- FSM states:
  - IDLE -> READ on accept.
  - READ: wait one cycle while the bank samples the addresses. -> EXEC.
  - EXEC: rd_data1/rd_data2 are valid.
    - ALU ops: compute and register the result. -> WB.
    - MUL: load multiplicand = rd_data1, multiplier = rd_data2, acc = 0, count = 0. -> MUL.
  - MUL: each cycle, if multiplier[0] then acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++. After WIDTH iterations -> WB.
  - WB: reg_write=1, wr_addr=dst, wr_data=result, done=1. -> IDLE.
- rd_addr1/rd_addr2 hold their values until the next accept.
- wr_addr/wr_data hold their last values after WB. reg_write is the only write qualifier.
- issue_ready is high only in IDLE. It is low while reset is asserted.
- Instructions presented while not ready are ignored. Upstream holds issue_valid and its fields until accept.
- dst = src1 or dst = src2 is legal. The write happens after both reads have been captured.
- Reset mid-operation:
  - state -> IDLE immediately; the in-flight instruction is abandoned with no write
  - all outputs return to reset values on the next edge

## Timing
- Edge numbering: accept at edge E0; cycle n follows edge En-1.
- ALU ops:
  - READ in cycle 1, EXEC in cycle 2, WB (reg_write high) in cycle 3
  - IDLE and issue_ready high in cycle 4
- MUL:
  - EXEC in cycle 2; MUL in cycles 3..WIDTH+2; WB in cycle WIDTH+3
  - issue_ready in cycle WIDTH+4. Cycle 35 / 36 for WIDTH=32.
- Maximum throughput is one ALU instruction per 4 cycles. Issue can occur on the first IDLE cycle after WB.
- Reset values:
  - issue_ready 0 (1 in the first cycle after reset deasserts)
  - busy 0, reg_write 0, done 0, err 0
  - rd_addr1 0, rd_addr2 0, wr_addr 0, wr_data 0
  - state IDLE, internal counters 0

## Configuration
- EXEC_MUL_EN defined:
  - op 110 is executed by the iterative multiplier as described above.
- EXEC_MUL_EN undefined:
  - the multiplier registers and the MUL state are not built
  - op 110 goes READ -> EXEC as normal, then EXEC -> IDLE with err=1 and done=1 for one cycle (cycle 2)
  - no reg_write; issue_ready is high in cycle 3

## Test plan
- ADD: bank r2=5, r3=7, issue ADD dst=4 src1=2 src2=3 -> cycle 3: reg_write=1, wr_addr=4, wr_data=12, done=1; issue_ready=1 in cycle 4.
- SUB wrap: r2=0, r3=1, SUB -> wr_data=0xFFFFFFFF. SLT with r2=0xFFFFFFFF, r3=1 -> wr_data=1. Swapped operands -> wr_data=0.
- MUL (EXEC_MUL_EN): r2=0xFFFF, r3=0xFFFF -> reg_write only in cycle 35 with wr_data=0xFFFE0001; busy high in cycles 1..35. MUL 0x80000000×2 -> 0.
- Back-to-back: issue_valid held high with 3 instructions -> accepts 4 cycles apart; exactly 3 reg_write pulses; dst=src1 case reads the old value.
- Reset at MUL cycle 10 -> no reg_write ever; busy=0 and issue_ready=0 during reset; issue_ready=1 on the first cycle after reset; a following ADD completes normally.
- EXEC_MUL_EN undefined, op=110 -> err=1 and done=1 in cycle 2; reg_write stays 0; issue_ready=1 in cycle 3.

Source files
------------

// File: rtl/exec_stage.sv
// Single-issue execute/write-back sequencer for the 8x32 register bank.
// Define EXEC_MUL_EN to build the iterative multiplier for op 110; otherwise that op raises err.
module exec_stage #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    dst,
    input  logic [AW-1:0]    src1,
    input  logic [AW-1:0]    src2,
    output logic [AW-1:0]    rd_addr1,
    output logic [AW-1:0]    rd_addr2,
    input  logic [WIDTH-1:0] rd_data1,
    input  logic [WIDTH-1:0] rd_data2,
    output logic             reg_write,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

`ifdef EXEC_MUL_EN
    typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, EXEC, WB} state_t;
`endif

    state_t          state;
    logic [2:0]      op_q;
    logic [AW-1:0]   dst_q;

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    count;

    // Shift-and-add step; the final step's sum goes straight to wr_data.
    assign acc_next = mplier[0] ? acc + mcand : acc;
`endif

    function automatic logic [WIDTH-1:0] alu(input logic [2:0] o,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        case (o)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MOV:  return a;
            default: return '0;
        endcase
    endfunction

    assign issue_ready = (state == IDLE) && !reset;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            rd_addr1  <= '0;
            rd_addr2  <= '0;
            reg_write <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef EXEC_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
`endif
        end else begin
            reg_write <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_valid) begin
                        op_q     <= op;
                        dst_q    <= dst;
                        rd_addr1 <= src1;
                        rd_addr2 <= src2;
                        state    <= READ;
                    end
                end
                READ: begin
                    state <= EXEC;
`ifndef EXEC_MUL_EN
                    // Without the multiplier, MUL is rejected during EXEC.
                    if (op_q == OP_MUL) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end
`endif
                end
                EXEC: begin
                    if (op_q == OP_MUL) begin
`ifdef EXEC_MUL_EN
                        mcand  <= rd_data1;
                        mplier <= rd_data2;
                        acc    <= '0;
                        count  <= '0;
                        state  <= MUL;
`else
                        state  <= IDLE;
`endif
                    end else begin
                        wr_addr   <= dst_q;
                        wr_data   <= alu(op_q, rd_data1, rd_data2);
                        reg_write <= 1'b1;
                        done      <= 1'b1;
                        state     <= WB;
                    end
                end
`ifdef EXEC_MUL_EN
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        wr_addr   <= dst_q;
                        wr_data   <= acc_next;
                        reg_write <= 1'b1;
                        done      <= 1'b1;
                        state     <= WB;
                    end
                end
`endif
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: a bank model feeds the DUT, a reference model predicts results.
// Honours EXEC_MUL_EN so the same bench covers both builds.
module tb_exec_stage;

    localparam int WIDTH = 32;
    localparam int AW    = 3;
`ifdef EXEC_MUL_EN
    localparam bit MULEN = 1'b1;
`else
    localparam bit MULEN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             issue_valid;
    logic             issue_ready;
    logic [2:0]       op;
    logic [AW-1:0]    dst;
    logic [AW-1:0]    src1;
    logic [AW-1:0]    src2;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             reg_write;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             done;
    logic             err;
    logic             busy;

    logic [WIDTH-1:0] bank [8];
    logic             tbWe;
    logic [AW-1:0]    tbAddr;
    logic [WIDTH-1:0] tbData;
    logic [WIDTH-1:0] refRegs [8];

    int compared   = 0;
    int mismatched = 0;

    exec_stage #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op(op), .dst(dst), .src1(src1), .src2(src2),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: registered reads, write port driven by the DUT or by bench preloads.
    always @(posedge clk) begin
        rd_data1 <= bank[rd_addr1];
        rd_data2 <= bank[rd_addr2];
        if (tbWe)
            bank[tbAddr] <= tbData;
        else if (reg_write)
            bank[wr_addr] <= wr_data;
    end

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] refResult(input logic [2:0] o,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return prod[31:0];
            default: return a;
        endcase
    endfunction

    task automatic loadReg(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        tbWe = 1'b1; tbAddr = a; tbData = d;
        @(negedge clk);
        tbWe = 1'b0;
        refRegs[a] = d;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_ready"}, issue_ready, 0);
        checkOutput({tag, "_reg_write"}, reg_write, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_rd_addr1"}, rd_addr1, 0);
        checkOutput({tag, "_rd_addr2"}, rd_addr2, 0);
        checkOutput({tag, "_wr_addr"}, wr_addr, 0);
        checkOutput({tag, "_wr_data"}, wr_data, 0);
    endtask

    // Issue one instruction from an idle negedge and check every cycle until the block is idle again.
    task automatic applyStimulus(input logic [2:0] o, input logic [AW-1:0] d,
                                 input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                 input bit hold);
        logic [WIDTH-1:0] expected;
        bit illegal;
        int last;
        illegal  = (o == 3'd6) && !MULEN;
        last     = illegal ? 2 : ((o == 3'd6) ? WIDTH + 3 : 3);
        expected = refResult(o, refRegs[s1], refRegs[s2]);
        issue_valid = 1'b1; op = o; dst = d; src1 = s1; src2 = s2;
        checkOutput("ready_before_issue", issue_ready, 1);
        @(posedge clk);
        if (!hold) #1 issue_valid = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            checkOutput("busy", busy, 1);
            checkOutput("ready_while_busy", issue_ready, 0);
            checkOutput("reg_write", reg_write, (!illegal && c == last) ? 1 : 0);
            checkOutput("err", err, (illegal && c == last) ? 1 : 0);
            checkOutput("done", done, (c == last) ? 1 : 0);
            if (c == 1) begin
                checkOutput("rd_addr1", rd_addr1, s1);
                checkOutput("rd_addr2", rd_addr2, s2);
            end
            if (c == last && !illegal) begin
                checkOutput("wr_addr", wr_addr, d);
                checkOutput("wr_data", wr_data, expected);
            end
        end
        @(negedge clk);
        checkOutput("ready_after", issue_ready, 1);
        checkOutput("busy_after", busy, 0);
        checkOutput("reg_write_after", reg_write, 0);
        if (!illegal) refRegs[d] = expected;
    endtask

    task automatic resetMidOp();
        loadReg(2, 32'h0000_FFFF);
        loadReg(3, 32'h0000_FFFF);
        @(negedge clk);
        issue_valid = 1'b1; op = MULEN ? 3'd6 : 3'd0; dst = 3'd4; src1 = 3'd2; src2 = 3'd3;
        @(posedge clk);
        #1 issue_valid = 1'b0;
        repeat (MULEN ? 10 : 2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkResetValues("mid_reset");
        end
        reset = 1'b0;
        #1 checkOutput("ready_after_reset", issue_ready, 1);
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            checkOutput("no_write_after_reset", reg_write, 0);
            checkOutput("idle_after_reset", busy, 0);
        end
        applyStimulus(3'd0, 3'd5, 3'd2, 3'd3, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] edgeVals [4];
        edgeVals[0] = 32'h0; edgeVals[1] = 32'hFFFF_FFFF;
        edgeVals[2] = 32'h8000_0000; edgeVals[3] = 32'h7FFF_FFFF;
        reset = 1'b1; issue_valid = 1'b0; op = '0; dst = '0; src1 = '0; src2 = '0;
        tbWe = 1'b0; tbAddr = '0; tbData = '0;
        repeat (3) @(negedge clk);
        checkResetValues("por");
        reset = 1'b0;
        #1 checkOutput("ready_first_cycle", issue_ready, 1);

        for (int r = 0; r < 8; r++) loadReg(AW'(r), $urandom);

        loadReg(2, 32'd5); loadReg(3, 32'd7);
        @(negedge clk);
        applyStimulus(3'd0, 3'd4, 3'd2, 3'd3, 1'b0);

        loadReg(2, 32'd0); loadReg(3, 32'd1);
        @(negedge clk);
        applyStimulus(3'd1, 3'd4, 3'd2, 3'd3, 1'b0);

        loadReg(2, 32'hFFFF_FFFF); loadReg(3, 32'd1);
        @(negedge clk);
        applyStimulus(3'd5, 3'd4, 3'd2, 3'd3, 1'b0);
        applyStimulus(3'd5, 3'd4, 3'd3, 3'd2, 1'b0);

        loadReg(2, 32'h0000_FFFF); loadReg(3, 32'h0000_FFFF);
        @(negedge clk);
        applyStimulus(3'd6, 3'd4, 3'd2, 3'd3, 1'b0);
        loadReg(2, 32'h8000_0000); loadReg(3, 32'd2);
        @(negedge clk);
        applyStimulus(3'd6, 3'd4, 3'd2, 3'd3, 1'b0);

        // Back-to-back with issue_valid held; the last one overwrites its own source.
        applyStimulus(3'd4, 3'd1, 3'd2, 3'd3, 1'b1);
        applyStimulus(3'd3, 3'd6, 3'd1, 3'd2, 1'b1);
        applyStimulus(3'd0, 3'd2, 3'd2, 3'd1, 1'b1);
        issue_valid = 1'b0;
        @(negedge clk);
        checkOutput("no_extra_issue", busy, 0);

        resetMidOp();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                loadReg(AW'($urandom_range(0, 7)),
                        ($urandom_range(0, 1) == 1) ? edgeVals[$urandom_range(0, 3)] : $urandom);
                @(negedge clk);
            end
            applyStimulus(3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          $urandom_range(0, 1) == 1);
            issue_valid = 1'b0;
        end

        for (int r = 0; r < 8; r++) checkOutput("bank_final", bank[r], refRegs[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
